// File: rtl/ex_mem_pipe_if.sv
// EX -> MEM stage bus: EX-side inputs, pipeline controls, and the MEM-side registered outputs.
interface ex_mem_pipe_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          stall;
  logic          flush;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_store_data;
  logic [DW-1:0] ex_pc_plus2;
  logic [RW-1:0] ex_dst_reg;
  logic          ex_RegWrite;
  logic          ex_MemtoReg;
  logic          ex_PCtoReg;
  logic          ex_Halt;
  logic          ex_MemWrite;
  logic          ex_MemRead;
  logic [2:0]    ex_flag_in;
  logic [2:0]    ex_flag_wen;

  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_store_data;
  logic [DW-1:0] mem_pc_plus2;
  logic [RW-1:0] mem_dst_reg;
  logic [3:0]    mem_wb_ctrl;
  logic          mem_MemWrite;
  logic          mem_MemRead;
  logic          mem_valid;
  logic [2:0]    flags;
  logic [DW-1:0] fwd_data;
  logic          fwd_en;
  logic          halted;

  modport master (
    output stall, flush, ex_alu_result, ex_store_data, ex_pc_plus2, ex_dst_reg,
           ex_RegWrite, ex_MemtoReg, ex_PCtoReg, ex_Halt, ex_MemWrite, ex_MemRead,
           ex_flag_in, ex_flag_wen,
    input  mem_alu_result, mem_store_data, mem_pc_plus2, mem_dst_reg, mem_wb_ctrl,
           mem_MemWrite, mem_MemRead, mem_valid, flags, fwd_data, fwd_en, halted
  );

  modport slave (
    input  stall, flush, ex_alu_result, ex_store_data, ex_pc_plus2, ex_dst_reg,
           ex_RegWrite, ex_MemtoReg, ex_PCtoReg, ex_Halt, ex_MemWrite, ex_MemRead,
           ex_flag_in, ex_flag_wen,
    output mem_alu_result, mem_store_data, mem_pc_plus2, mem_dst_reg, mem_wb_ctrl,
           mem_MemWrite, mem_MemRead, mem_valid, flags, fwd_data, fwd_en, halted
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with architectural Z/V/N flag register and a sticky halt lock
// that turns every later non-stalled edge into a bubble.
module ex_mem_pipe #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_pipe_if.slave bus
);

  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [DW-1:0] store_data_q, store_data_d;
  logic [DW-1:0] pc_plus2_q,   pc_plus2_d;
  logic [RW-1:0] dst_reg_q,    dst_reg_d;
  logic [3:0]    wb_ctrl_q,    wb_ctrl_d;
  logic          mem_write_q,  mem_write_d;
  logic          mem_read_q,   mem_read_d;
  logic          valid_q,      valid_d;
  logic [2:0]    flags_q,      flags_d;
  logic          halted_q,     halted_d;

  // Next-state selection: stall holds everything, flush/halt inserts a bubble, otherwise load.
  always_comb begin
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    pc_plus2_d   = pc_plus2_q;
    dst_reg_d    = dst_reg_q;
    wb_ctrl_d    = wb_ctrl_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    valid_d      = valid_q;
    flags_d      = flags_q;
    halted_d     = halted_q;
    if (bus.stall) begin
      halted_d = halted_q;
    end else if (bus.flush || halted_q) begin
      // Bubble: nothing may look like a register write or forwarding source.
      alu_result_d = {DW{1'b0}};
      store_data_d = {DW{1'b0}};
      pc_plus2_d   = {DW{1'b0}};
      dst_reg_d    = {RW{1'b0}};
      wb_ctrl_d    = 4'b0000;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      valid_d      = 1'b0;
    end else begin
      alu_result_d = bus.ex_alu_result;
      store_data_d = bus.ex_store_data;
      pc_plus2_d   = bus.ex_pc_plus2;
      dst_reg_d    = bus.ex_dst_reg;
      wb_ctrl_d    = {bus.ex_RegWrite, bus.ex_MemtoReg, bus.ex_PCtoReg, bus.ex_Halt};
      mem_write_d  = bus.ex_MemWrite;
      mem_read_d   = bus.ex_MemRead;
      valid_d      = 1'b1;
      flags_d      = (bus.ex_flag_wen & bus.ex_flag_in) | (~bus.ex_flag_wen & flags_q);
      halted_d     = halted_q | bus.ex_Halt;
    end
  end

  // Stage state register; reset overrides stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= {DW{1'b0}};
      store_data_q <= {DW{1'b0}};
      pc_plus2_q   <= {DW{1'b0}};
      dst_reg_q    <= {RW{1'b0}};
      wb_ctrl_q    <= 4'b0000;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      valid_q      <= 1'b0;
      flags_q      <= 3'b000;
      halted_q     <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      pc_plus2_q   <= pc_plus2_d;
      dst_reg_q    <= dst_reg_d;
      wb_ctrl_q    <= wb_ctrl_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      valid_q      <= valid_d;
      flags_q      <= flags_d;
      halted_q     <= halted_d;
    end
  end

  // Output mapping and forwarding; load results are not yet available at this stage.
  always_comb begin
    bus.mem_alu_result = alu_result_q;
    bus.mem_store_data = store_data_q;
    bus.mem_pc_plus2   = pc_plus2_q;
    bus.mem_dst_reg    = dst_reg_q;
    bus.mem_wb_ctrl    = wb_ctrl_q;
    bus.mem_MemWrite   = mem_write_q;
    bus.mem_MemRead    = mem_read_q;
    bus.mem_valid      = valid_q;
    bus.flags          = flags_q;
    bus.halted         = halted_q;
    bus.fwd_en         = valid_q & wb_ctrl_q[3] & ~mem_read_q;
    if (wb_ctrl_q[1]) begin
      bus.fwd_data = pc_plus2_q;
    end else begin
      bus.fwd_data = alu_result_q;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed-vector bench for ex_mem_pipe: reset, load/flags, stall vs flush, halt lock,
// forwarding select and reset during stall, with hand-computed expectations.
module tb_ex_mem_pipe;

  localparam int DW = 16;
  localparam int RW = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ex_mem_pipe_if #(.DW(DW), .RW(RW)) bus_if ();

  ex_mem_pipe #(.DW(DW), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] alu, input logic [15:0] sd, input logic [15:0] pc2,
                       input logic [3:0] dst, input logic [3:0] wb, input logic mw,
                       input logic mr, input logic [2:0] fin, input logic [2:0] fwen);
    bus_if.ex_alu_result = alu;
    bus_if.ex_store_data = sd;
    bus_if.ex_pc_plus2   = pc2;
    bus_if.ex_dst_reg    = dst;
    bus_if.ex_RegWrite   = wb[3];
    bus_if.ex_MemtoReg   = wb[2];
    bus_if.ex_PCtoReg    = wb[1];
    bus_if.ex_Halt       = wb[0];
    bus_if.ex_MemWrite   = mw;
    bus_if.ex_MemRead    = mr;
    bus_if.ex_flag_in    = fin;
    bus_if.ex_flag_wen   = fwen;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.stall = 1'b0;
    bus_if.flush = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'b1111, 1'b1, 1'b1, 3'b111, 3'b111);
    step();
    step();
    chk("rst_alu",    32'(bus_if.mem_alu_result), 32'h0);
    chk("rst_sd",     32'(bus_if.mem_store_data), 32'h0);
    chk("rst_pc2",    32'(bus_if.mem_pc_plus2),   32'h0);
    chk("rst_dst",    32'(bus_if.mem_dst_reg),    32'h0);
    chk("rst_wb",     32'(bus_if.mem_wb_ctrl),    32'h0);
    chk("rst_mw",     32'(bus_if.mem_MemWrite),   32'h0);
    chk("rst_mr",     32'(bus_if.mem_MemRead),    32'h0);
    chk("rst_valid",  32'(bus_if.mem_valid),      32'h0);
    chk("rst_flags",  32'(bus_if.flags),          32'h0);
    chk("rst_halted", 32'(bus_if.halted),         32'h0);
    chk("rst_fwd_en", 32'(bus_if.fwd_en),         32'h0);

    // Load with all flags written.
    rst = 1'b0;
    drive(16'h1234, 16'h5678, 16'h0010, 4'd5, 4'b1000, 1'b0, 1'b0, 3'b101, 3'b111);
    step();
    chk("ld_alu",    32'(bus_if.mem_alu_result), 32'h1234);
    chk("ld_sd",     32'(bus_if.mem_store_data), 32'h5678);
    chk("ld_dst",    32'(bus_if.mem_dst_reg),    32'h5);
    chk("ld_wb",     32'(bus_if.mem_wb_ctrl),    32'h8);
    chk("ld_valid",  32'(bus_if.mem_valid),      32'h1);
    chk("ld_flags",  32'(bus_if.flags),          32'h5);
    chk("ld_fwd_en", 32'(bus_if.fwd_en),         32'h1);
    chk("ld_fwd",    32'(bus_if.fwd_data),       32'h1234);

    // Only V written with 0: Z,N held -> 101.
    drive(16'h2222, 16'h0000, 16'h0012, 4'd6, 4'b1000, 1'b0, 1'b0, 3'b000, 3'b010);
    step();
    chk("wenV_flags", 32'(bus_if.flags),          32'h5);
    chk("wenV_alu",   32'(bus_if.mem_alu_result), 32'h2222);

    // Z<=0, V<=1, N held at 1 -> 011.
    drive(16'h1234, 16'h0000, 16'h0014, 4'd5, 4'b1000, 1'b0, 1'b0, 3'b010, 3'b110);
    step();
    chk("wenZV_flags", 32'(bus_if.flags), 32'h3);

    // Stall wins over flush: nothing changes.
    bus_if.stall = 1'b1;
    bus_if.flush = 1'b1;
    drive(16'hBEEF, 16'hBEEF, 16'hBEEF, 4'd9, 4'b1000, 1'b1, 1'b0, 3'b111, 3'b111);
    step();
    chk("stl_alu",   32'(bus_if.mem_alu_result), 32'h1234);
    chk("stl_dst",   32'(bus_if.mem_dst_reg),    32'h5);
    chk("stl_valid", 32'(bus_if.mem_valid),      32'h1);
    chk("stl_mw",    32'(bus_if.mem_MemWrite),   32'h0);
    chk("stl_flags", 32'(bus_if.flags),          32'h3);

    // Flush alone: bubble, flags held.
    bus_if.stall = 1'b0;
    step();
    chk("fl_valid",  32'(bus_if.mem_valid),      32'h0);
    chk("fl_wb",     32'(bus_if.mem_wb_ctrl),    32'h0);
    chk("fl_alu",    32'(bus_if.mem_alu_result), 32'h0);
    chk("fl_dst",    32'(bus_if.mem_dst_reg),    32'h0);
    chk("fl_mw",     32'(bus_if.mem_MemWrite),   32'h0);
    chk("fl_flags",  32'(bus_if.flags),          32'h3);
    chk("fl_fwd_en", 32'(bus_if.fwd_en),         32'h0);

    // HLT enters MEM and locks the stage.
    bus_if.flush = 1'b0;
    drive(16'h0AAA, 16'h0000, 16'h0020, 4'd0, 4'b0001, 1'b0, 1'b0, 3'b000, 3'b000);
    step();
    chk("hlt_wb",     32'(bus_if.mem_wb_ctrl),    32'h1);
    chk("hlt_halted", 32'(bus_if.halted),         32'h1);
    chk("hlt_valid",  32'(bus_if.mem_valid),      32'h1);
    chk("hlt_alu",    32'(bus_if.mem_alu_result), 32'h0AAA);

    drive(16'h3333, 16'h0000, 16'h0022, 4'd3, 4'b1000, 1'b0, 1'b0, 3'b100, 3'b111);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_valid",  32'(bus_if.mem_valid),      32'h0);
      chk("lock_alu",    32'(bus_if.mem_alu_result), 32'h0);
      chk("lock_flags",  32'(bus_if.flags),          32'h3);
      chk("lock_halted", 32'(bus_if.halted),         32'h1);
    end

    rst = 1'b1;
    step();
    chk("hrst_halted", 32'(bus_if.halted), 32'h0);
    chk("hrst_flags",  32'(bus_if.flags),  32'h0);
    rst = 1'b0;
    drive(16'h4444, 16'h0000, 16'h0024, 4'd4, 4'b1000, 1'b0, 1'b0, 3'b111, 3'b001);
    step();
    chk("post_valid",  32'(bus_if.mem_valid),      32'h1);
    chk("post_alu",    32'(bus_if.mem_alu_result), 32'h4444);
    chk("post_halted", 32'(bus_if.halted),         32'h0);
    chk("post_flags",  32'(bus_if.flags),          32'h1);

    // Forwarding source select and load suppression.
    drive(16'h9999, 16'h0000, 16'h0042, 4'd7, 4'b1010, 1'b0, 1'b0, 3'b000, 3'b000);
    step();
    chk("pcs_fwd",    32'(bus_if.fwd_data),     32'h0042);
    chk("pcs_fwd_en", 32'(bus_if.fwd_en),       32'h1);
    chk("pcs_pc2",    32'(bus_if.mem_pc_plus2), 32'h0042);

    drive(16'h9999, 16'h0000, 16'h0042, 4'd8, 4'b1100, 1'b0, 1'b1, 3'b000, 3'b000);
    step();
    chk("lw_fwd_en", 32'(bus_if.fwd_en),      32'h0);
    chk("lw_fwd",    32'(bus_if.fwd_data),    32'h9999);
    chk("lw_mr",     32'(bus_if.mem_MemRead), 32'h1);

    drive(16'h0100, 16'hCAFE, 16'h0046, 4'd0, 4'b0000, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    chk("sw_mw",     32'(bus_if.mem_MemWrite),   32'h1);
    chk("sw_sd",     32'(bus_if.mem_store_data), 32'hCAFE);
    chk("sw_fwd_en", 32'(bus_if.fwd_en),         32'h0);

    // Reset during stall clears everything.
    bus_if.stall = 1'b1;
    rst = 1'b1;
    step();
    chk("rs_valid", 32'(bus_if.mem_valid),      32'h0);
    chk("rs_sd",    32'(bus_if.mem_store_data), 32'h0);
    chk("rs_mw",    32'(bus_if.mem_MemWrite),   32'h0);
    chk("rs_flags", 32'(bus_if.flags),          32'h0);
    rst = 1'b0;
    step();
    chk("rs_hold_valid", 32'(bus_if.mem_valid),      32'h0);
    chk("rs_hold_alu",   32'(bus_if.mem_alu_result), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
EX/MEM pipeline stage register. Sits directly downstream of the ID/EX register and the ALU: it captures the EX-stage result, store data, destination register and MEM/WB control bits, and presents them to the data-memory stage. It also owns the architectural flag register (Z, V, N), which is committed only when an instruction actually advances out of EX. It provides a halt lock so no instruction enters MEM after a HLT has passed EX.

Parameters:
DW, 16, datapath width (ALU result, store data, PC)
RW, 4, register-specifier width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
stall  in  1  hold all stage contents; no load, no flag update
flush  in  1  load a bubble instead of EX contents
ex_alu_result  in  DW  ALU output / effective address
ex_store_data  in  DW  forwarded rt value for SW
ex_pc_plus2  in  DW  PC+2 for PCS
ex_dst_reg  in  RW  destination register specifier
ex_RegWrite  in  1  WB control
ex_MemtoReg  in  1  WB control
ex_PCtoReg  in  1  WB control
ex_Halt  in  1  WB control
ex_MemWrite  in  1  MEM control
ex_MemRead  in  1  MEM control
ex_flag_in  in  3  {Z,V,N} computed by ALU
ex_flag_wen  in  3  per-flag write enables {Z,V,N}
mem_alu_result  out  DW  registered ALU result (memory address)
mem_store_data  out  DW  registered store data
mem_pc_plus2  out  DW  registered PC+2
mem_dst_reg  out  RW  registered destination
mem_wb_ctrl  out  4  {RegWrite, MemtoReg, PCtoReg, Halt}
mem_MemWrite  out  1  registered
mem_MemRead  out  1  registered
mem_valid  out  1  1 = real instruction, 0 = bubble
flags  out  3  architectural {Z,V,N}
fwd_data  out  DW  EX->EX forwarding value: mem_pc_plus2 if PCtoReg else mem_alu_result
fwd_en  out  1  mem_valid & RegWrite & ~MemRead (load data not forwardable from here)
halted  out  1  sticky: a HLT has been loaded into this stage

Behaviour:
- All state updates on rising clk. Per-edge priority: rst > stall > (flush | halted) > load.
- rst=1: every registered output and flags = 0, halted = 0, mem_valid = 0. Reset mid-stall or mid-flush wins unconditionally.
- stall=1 (rst=0): all stage registers, flags and halted hold. stall overrides a simultaneous flush.
- Bubble (flush=1 or halted=1, stall=0): mem_valid=0; all control bits, dst_reg and data fields = 0; flags hold; halted holds.
- Load (stall=0, flush=0, halted=0): all ex_* fields captured; mem_valid=1; for each i in {Z,V,N}: flags[i] <= ex_flag_wen[i] ? ex_flag_in[i] : flags[i]. If ex_Halt=1, halted <= 1 on the same edge.
- halted clears only on rst. After a HLT is loaded, every subsequent non-stall edge loads a bubble, so MEM/WB never see a younger instruction.
- Latency: exactly one cycle from EX inputs to mem_* outputs. Flags are visible one cycle after the flag-setting instruction leaves EX, so a branch in the next EX reads them without a bubble.
- fwd_data and fwd_en are purely combinational from registered state; no input-to-output combinational path through the stage.
- Bubble with dst_reg=0 and RegWrite=0 never triggers forwarding or a write.
- Widths are fixed; no arithmetic is performed in this block.

Test Plan:
- Reset: hold rst=1 with all ex_* = 1s for 2 edges -> every output 0, halted=0, mem_valid=0.
- Load/flags: ALU 0x1234, dst 5, RegWrite=1, flag_in=3'b101, wen=3'b111 -> next cycle mem_alu_result=0x1234, mem_dst_reg=5, flags=101, fwd_en=1, fwd_data=0x1234. Then flag_in=000, wen=3'b010 -> flags=101 (only V written, V was 0).
- Stall vs flush: stall=1 and flush=1 together with new inputs 0xBEEF -> outputs stay 0x1234, flags unchanged. Next edge flush=1 only -> mem_valid=0, all ctrl=0, flags unchanged.
- Halt lock: load with ex_Halt=1 -> mem_wb_ctrl[0]=1, halted=1. Next 3 edges with valid ADD inputs -> mem_valid=0 each cycle. Then rst -> halted=0, and the next load is accepted.
- Forwarding select: PCtoReg=1, pc_plus2=0x0042, alu=0x9999 -> fwd_data=0x0042. MemRead=1, RegWrite=1 -> fwd_en=0.
- Reset mid-stall: stall=1 with valid contents, assert rst for one edge -> all outputs cleared despite stall.
